burst_sequencer: RTL

BURST_SEQUENCER -- requirements
Module: burst_sequencer

---
 rtl/burst_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/burst_sequencer.sv
// burst_sequencer
//   Splits a byte-addressed transfer (address, length) into AXI-style bursts
//   that never cross a 4 KB boundary and never exceed MAX_BURST_BEATS beats.
//   One burst is outstanding at a time: address phase (ax_*), then beat_en
//   consumes its data beats, with beat_strb and beat_last describing the
//   beat currently offered.
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start, address, length      transfer request (sampled when accepted in idle)
//   busy, done                  transfer in progress / one-cycle completion pulse
//   ax_valid, ax_ready          burst address handshake
//   ax_addr, ax_len             aligned burst address, beats minus one
//   beat_en                     one data beat consumed this cycle
//   beat_strb, beat_last        byte strobe and last-beat flag of the current beat
module burst_sequencer #(
  parameter int AXI_ADDR_W      = 32,
  parameter int AXI_DATA_W      = 32,
  parameter int LEN_W           = 32,
  parameter int MAX_BURST_BEATS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AXI_ADDR_W-1:0]   address,
  input  logic [LEN_W-1:0]        length,
  output logic                    busy,
  output logic                    done,
  output logic                    ax_valid,
  input  logic                    ax_ready,
  output logic [AXI_ADDR_W-1:0]   ax_addr,
  output logic [7:0]              ax_len,
  input  logic                    beat_en,
  output logic [AXI_DATA_W/8-1:0] beat_strb,
  output logic                    beat_last
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  // Burst arithmetic width: wide enough for LEN_W and for the largest
  // beat-limit byte count (256 beats * 128 bytes) plus an offset.
  localparam int CW     = (LEN_W > 18) ? LEN_W : 18;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_FIN} state_t;

  state_t                  state_q;
  logic                    busy_q, done_q, ax_valid_q;
  logic [AXI_ADDR_W-1:0]   ax_addr_q;
  logic [7:0]              ax_len_q;
  logic [7:0]              beat_cnt_q;
  logic [AXI_ADDR_W-1:0]   cur_addr_q;
  logic [LEN_W-1:0]        rem_q;
  logic                    first_q, last_burst_q;
  logic [OFF_W-1:0]        start_off_q, end_off_q;

  // Next-burst calculation, shared by the first burst (from the inputs while
  // idle) and every later burst (from the running address/remaining count).
  logic [AXI_ADDR_W-1:0]   calc_addr;
  logic [LEN_W-1:0]        calc_rem;
  logic [OFF_W-1:0]        calc_off;
  logic [12:0]             to_4k;
  logic [CW-1:0]           rem_w, bytes, beats;
  logic [AXI_ADDR_W-1:0]   ax_addr_d, cur_addr_d;
  logic [7:0]              ax_len_d;
  logic [LEN_W-1:0]        rem_d;
  logic                    last_burst_d;
  logic [OFF_W-1:0]        start_off_d, end_off_d;

  always_comb begin
    calc_addr    = (state_q == S_IDLE) ? address : cur_addr_q;
    calc_rem     = (state_q == S_IDLE) ? length : rem_q;
    calc_off     = calc_addr[OFF_W-1:0];
    to_4k        = 13'h1000 - {1'b0, calc_addr[11:0]};
    rem_w        = CW'(calc_rem);
    bytes        = CW'(MAX_BURST_BEATS * STRB_W) - CW'(calc_off);
    if (CW'(to_4k) < bytes) bytes = CW'(to_4k);
    if (rem_w < bytes)      bytes = rem_w;
    beats        = (CW'(calc_off) + bytes + CW'(STRB_W - 1)) >> OFF_W;
    ax_addr_d    = {calc_addr[AXI_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    ax_len_d     = 8'(beats - CW'(1));
    // A burst that does not finish the transfer always ends on an aligned
    // boundary, so later bursts start aligned.
    cur_addr_d   = calc_addr + AXI_ADDR_W'(bytes);
    rem_d        = calc_rem - LEN_W'(bytes);
    last_burst_d = (rem_w == bytes);
    start_off_d  = address[OFF_W-1:0];
    end_off_d    = address[OFF_W-1:0] + length[OFF_W-1:0] - OFF_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ax_valid_q   <= 1'b0;
      ax_addr_q    <= '0;
      ax_len_q     <= '0;
      beat_cnt_q   <= '0;
      cur_addr_q   <= '0;
      rem_q        <= '0;
      first_q      <= 1'b0;
      last_burst_q <= 1'b0;
      start_off_q  <= '0;
      end_off_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (length == '0) begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_ADDR;
              ax_valid_q   <= 1'b1;
              ax_addr_q    <= ax_addr_d;
              ax_len_q     <= ax_len_d;
              cur_addr_q   <= cur_addr_d;
              rem_q        <= rem_d;
              last_burst_q <= last_burst_d;
              first_q      <= 1'b1;
              start_off_q  <= start_off_d;
              end_off_q    <= end_off_d;
            end
          end
        end
        S_ADDR: begin
          if (ax_ready) begin
            ax_valid_q <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= S_DATA;
          end
        end
        S_DATA: begin
          if (beat_en) begin
            if (beat_cnt_q == ax_len_q) begin
              beat_cnt_q <= '0;
              first_q    <= 1'b0;
              if (last_burst_q) begin
                state_q <= S_FIN;
                done_q  <= 1'b1;
              end else begin
                state_q      <= S_ADDR;
                ax_valid_q   <= 1'b1;
                ax_addr_q    <= ax_addr_d;
                ax_len_q     <= ax_len_d;
                cur_addr_q   <= cur_addr_d;
                rem_q        <= rem_d;
                last_burst_q <= last_burst_d;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        S_FIN: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ax_valid  = ax_valid_q;
  assign ax_addr   = ax_addr_q;
  assign ax_len    = ax_len_q;
  assign beat_last = (state_q == S_DATA) && (beat_cnt_q == ax_len_q);

  // Leading bytes are masked on the very first beat of the transfer and
  // trailing bytes on the very last; a single-beat transfer gets both.
  always_comb begin
    beat_strb = '1;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (first_q && (beat_cnt_q == '0) && (OFF_W'(i) < start_off_q))
        beat_strb[i] = 1'b0;
      if (last_burst_q && beat_last && (OFF_W'(i) > end_off_q))
        beat_strb[i] = 1'b0;
    end
  end

endmodule
